// File: rtl/ifft_radix2_engine.sv
// Iterative in-place radix-2 DIT FFT/IFFT over a register-array buffer.
// Frames load in bit-reversed order, run LOG2N stages of butterflies, and unload in natural order.
module ifft_radix2_engine #(
  parameter int LOG2N = 3,
  parameter int IW    = 8,
  parameter int TW    = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inv,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IW-1:0]      in_i,
  input  logic [IW-1:0]      in_q,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IW+LOG2N:0]  out_i,
  output logic [IW+LOG2N:0]  out_q,
  output logic [LOG2N-1:0]   out_index,
  output logic               out_last,
  output logic               busy
);

  localparam int  N    = 1 << LOG2N;
  localparam int  H    = N / 2;
  localparam int  DW   = IW + LOG2N + 1;
  localparam int  PW   = DW + TW + 1;
  localparam int  TMAX = (1 << (TW - 1)) - 1;
  localparam real PI   = 3.14159265358979323846;
  localparam real TSCL = real'(1 << (TW - 1));

  localparam logic [LOG2N-1:0] IDX_LAST = '1;
  localparam logic [LOG2N-1:0] ONE_N    = 1;
  localparam logic [LOG2N-2:0] BF_LAST  = '1;
  localparam logic [LOG2N-2:0] ONE_B    = 1;
  localparam logic [2:0]       STG_LAST = 3'(LOG2N - 1);
  localparam logic signed [PW-1:0] RND  = PW'(1 << (TW - 2));

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

  state_t state, state_nxt;

  logic [LOG2N-1:0] load_cnt;
  logic [LOG2N-1:0] out_cnt;
  logic [LOG2N-2:0] bfly_cnt;
  logic [2:0]       stage_cnt;
  logic             inv_q;

  logic signed [DW-1:0] mem_i [N];
  logic signed [DW-1:0] mem_q [N];

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  // Twiddle table: entry k holds cos/sin(2*pi*k/N) in Q1.(TW-1); +1.0 saturates.
  logic signed [TW-1:0] tw_cos [H];
  logic signed [TW-1:0] tw_sin [H];

  for (genvar g = 0; g < H; g++) begin : g_tw
    localparam real ANG   = 2.0 * PI * real'(g) / real'(N);
    localparam int  C_RAW = int'($cos(ANG) * TSCL);
    localparam int  S_RAW = int'($sin(ANG) * TSCL);
    localparam int  C_SAT = (C_RAW > TMAX) ? TMAX : C_RAW;
    localparam int  S_SAT = (S_RAW > TMAX) ? TMAX : S_RAW;
    assign tw_cos[g] = TW'(C_SAT);
    assign tw_sin[g] = TW'(S_SAT);
  end

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; valid never waits on ready, and ready is a pure function of state.
  logic last_stage;
  assign last_stage = (stage_cnt == STG_LAST);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && load_cnt == IDX_LAST) state_nxt = S_COMPUTE;
      end
      S_COMPUTE: begin
        busy = 1'b1;
        if (bfly_cnt == BF_LAST && last_stage) state_nxt = S_UNLOAD;
      end
      S_UNLOAD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready && out_cnt == IDX_LAST) state_nxt = S_LOAD;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_LOAD;
      load_cnt  <= '0;
      out_cnt   <= '0;
      bfly_cnt  <= '0;
      stage_cnt <= '0;
      inv_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            if (load_cnt == '0) inv_q <= inv;
            load_cnt <= load_cnt + ONE_N;
          end
        end
        S_COMPUTE: begin
          bfly_cnt <= bfly_cnt + ONE_B;
          if (bfly_cnt == BF_LAST) stage_cnt <= last_stage ? 3'd0 : stage_cnt + 3'd1;
        end
        S_UNLOAD: begin
          if (out_ready) out_cnt <= out_cnt + ONE_N;
        end
        default: ;
      endcase
    end
  end

  // Operand addressing for span h = 2^stage: top = (b/h)*2h + b%h, bot = top + h.
  logic [LOG2N-2:0] lo_mask;
  logic [LOG2N-2:0] b_lo;
  logic [LOG2N-1:0] b_ext;
  logic [LOG2N-1:0] addr_top;
  logic [LOG2N-1:0] addr_bot;
  logic [LOG2N-2:0] tw_idx;

  always_comb begin
    lo_mask  = (ONE_B << stage_cnt) - ONE_B;
    b_lo     = bfly_cnt & lo_mask;
    b_ext    = {1'b0, bfly_cnt};
    addr_top = ((b_ext >> stage_cnt) << (stage_cnt + 3'd1)) | {1'b0, b_lo};
    addr_bot = addr_top | (ONE_N << stage_cnt);
    tw_idx   = b_lo << (STG_LAST - stage_cnt);
  end

  logic signed [DW-1:0] top_i, top_q, bot_i, bot_q;
  logic signed [TW-1:0] w_c, w_s;
  logic signed [PW-1:0] prod_i, prod_q;
  logic signed [DW-1:0] t_i, t_q;

  always_comb begin
    top_i  = mem_i[addr_top];
    top_q  = mem_q[addr_top];
    bot_i  = mem_i[addr_bot];
    bot_q  = mem_q[addr_bot];
    w_c    = tw_cos[tw_idx];
    w_s    = inv_q ? tw_sin[tw_idx] : -tw_sin[tw_idx];
    prod_i = PW'(bot_i) * PW'(w_c) - PW'(bot_q) * PW'(w_s) + RND;
    prod_q = PW'(bot_q) * PW'(w_c) + PW'(bot_i) * PW'(w_s) + RND;
    // k = 0 is W = 1: pass bot through so impulse and DC frames stay exact.
    if (tw_idx == '0) begin
      t_i = bot_i;
      t_q = bot_q;
    end else begin
      t_i = DW'(prod_i >>> (TW - 1));
      t_q = DW'(prod_q >>> (TW - 1));
    end
  end

  logic [LOG2N-1:0] load_addr;
  assign load_addr = bitrev(load_cnt);

  always_ff @(posedge clk) begin
    if (state == S_LOAD && in_valid) begin
      mem_i[load_addr] <= {{(DW-IW){in_i[IW-1]}}, in_i};
      mem_q[load_addr] <= {{(DW-IW){in_q[IW-1]}}, in_q};
    end else if (state == S_COMPUTE) begin
      mem_i[addr_top] <= top_i + t_i;
      mem_q[addr_top] <= top_q + t_q;
      mem_i[addr_bot] <= top_i - t_i;
      mem_q[addr_bot] <= top_q - t_q;
    end
  end

  always_comb begin
    out_i     = '0;
    out_q     = '0;
    out_last  = 1'b0;
    out_index = out_cnt;
    if (state == S_UNLOAD) begin
      out_i    = mem_i[out_cnt];
      out_q    = mem_q[out_cnt];
      out_last = (out_cnt == IDX_LAST);
    end
  end

endmodule

// File: tb/tb_ifft_radix2_engine.sv
// Bench for ifft_radix2_engine: table vectors, randomized frames against a direct DFT model,
// backpressure, mid-compute reset, and a full-scale 64-point DC frame on a second instance.
module tb_ifft_radix2_engine;

  localparam int  LOG2N = 3;
  localparam int  N     = 8;
  localparam int  IW    = 8;
  localparam int  TW    = 12;
  localparam int  DW    = IW + LOG2N + 1;
  localparam int  NB    = 64;
  localparam int  DWB   = IW + 6 + 1;
  localparam real PI    = 3.14159265358979323846;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             inv, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [IW-1:0]    in_i, in_q;
  logic [DW-1:0]    out_i, out_q;
  logic [LOG2N-1:0] out_index;

  logic             b_inv, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
  logic [IW-1:0]    b_in_i, b_in_q;
  logic [DWB-1:0]   b_out_i, b_out_q;
  logic [5:0]       b_out_index;

  ifft_radix2_engine #(.LOG2N(LOG2N), .IW(IW), .TW(TW)) dut (
    .clk(clk), .rst(rst), .inv(inv), .in_valid(in_valid), .in_ready(in_ready),
    .in_i(in_i), .in_q(in_q), .out_valid(out_valid), .out_ready(out_ready),
    .out_i(out_i), .out_q(out_q), .out_index(out_index), .out_last(out_last), .busy(busy)
  );

  ifft_radix2_engine #(.LOG2N(6), .IW(IW), .TW(TW)) dut64 (
    .clk(clk), .rst(rst), .inv(b_inv), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_i(b_in_i), .in_q(b_in_q), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_i(b_out_i), .out_q(b_out_q), .out_index(b_out_index), .out_last(b_out_last),
    .busy(b_busy)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  int drv_i[N], drv_q[N], got_i[N], got_q[N];
  logic [2*DW-1:0] exp_q[$];

  task automatic check(input string name, input longint act, input longint expv, input longint tol);
    longint d;
    n_total++;
    d = act - expv;
    if (d < 0) d = -d;
    if (d <= tol) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, expv, tol);
  endtask

  task automatic push_exp(input int re, input int im);
    logic [DW-1:0] r, m;
    r = DW'(re);
    m = DW'(im);
    exp_q.push_back({r, m});
  endtask

  // Direct DFT with real arithmetic: X[m] = sum x[n] * exp(sign * j*2*pi*n*m/N).
  task automatic model_push(input bit m_inv);
    real ar, ai, ang, sg;
    sg = m_inv ? 1.0 : -1.0;
    for (int m = 0; m < N; m++) begin
      ar = 0.0;
      ai = 0.0;
      for (int n = 0; n < N; n++) begin
        ang = sg * 2.0 * PI * real'((n * m) % N) / real'(N);
        ar += real'(drv_i[n]) * $cos(ang) - real'(drv_q[n]) * $sin(ang);
        ai += real'(drv_i[n]) * $sin(ang) + real'(drv_q[n]) * $cos(ang);
      end
      push_exp(int'(ar), int'(ai));
    end
  endtask

  task automatic score(input string name, input int tol);
    logic [2*DW-1:0] e;
    for (int m = 0; m < N; m++) begin
      if (exp_q.size() == 0) begin
        check($sformatf("%s_exp_empty%0d", name, m), 0, 1, 0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s_re%0d", name, m), got_i[m], $signed(e[2*DW-1:DW]), tol);
        check($sformatf("%s_im%0d", name, m), got_q[m], $signed(e[DW-1:0]), tol);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_frame(input bit m_inv, input bit gaps, input bit hold);
    int w;
    for (int n = 0; n < N; n++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_i = IW'(drv_i[n]);
      in_q = IW'(drv_q[n]);
      inv  = (n == 0) ? m_inv : ~m_inv;
      w = 0;
      while (!in_ready && w < 50) begin
        @(posedge clk); #1;
        w++;
      end
      if (!in_ready) check("load_ready_timeout", 0, 1, 0);
      @(posedge clk); #1;
    end
    in_valid = hold;
    check("in_ready_after_load", in_ready, 0, 0);
    check("busy_in_compute", busy, 1, 0);
  endtask

  task automatic wait_compute();
    int cnt;
    cnt = 0;
    while (!out_valid && cnt < 1000) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("compute_latency", cnt, LOG2N * N / 2, 0);
  endtask

  task automatic unload_frame(input bit bp, input bit hold);
    int idx, cyc;
    bit stalled;
    longint st_i, st_q;
    bit pat[4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    idx = 0; cyc = 0; stalled = 1'b0; st_i = 0; st_q = 0;
    while (idx < N && cyc < 20 * N) begin
      out_ready = bp ? pat[cyc % 4] : 1'b1;
      @(negedge clk);
      if (hold) check("in_ready_blocked", in_ready, 0, 0);
      if (stalled) begin
        check("stall_hold_re", $signed(out_i), st_i, 0);
        check("stall_hold_im", $signed(out_q), st_q, 0);
      end
      stalled = 1'b0;
      check("out_valid_held", out_valid, 1, 0);
      if (out_valid) begin
        check("out_index", out_index, idx, 0);
        check("out_last", out_last, (idx == N - 1) ? 1 : 0, 0);
        if (out_ready) begin
          got_i[idx] = $signed(out_i);
          got_q[idx] = $signed(out_q);
          idx++;
        end else begin
          stalled = 1'b1;
          st_i = $signed(out_i);
          st_q = $signed(out_q);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (idx < N) check("unload_count", idx, N, 0);
    check("ready_after_last", in_ready, 1, 0);
    check("valid_after_last", out_valid, 0, 0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic set_impulse();
    for (int n = 0; n < N; n++) begin
      drv_i[n] = (n == 0) ? 127 : 0;
      drv_q[n] = 0;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic             inv;
    logic [3:0]       tol;
    logic [N-1:0][15:0] xi;
    logic [N-1:0][15:0] xq;
    logic [N-1:0][15:0] ei;
    logic [N-1:0][15:0] eq;
  } vec_t;

  vec_t  vecs[4];
  string vnames[4];
  int    sh_r[8];
  int    sh_q[8];

  initial begin : main
    int cnt, idx, cyc, er;
    rst = 1'b1; inv = 1'b0; in_valid = 1'b0; in_i = '0; in_q = '0; out_ready = 1'b0;
    b_inv = 1'b0; b_in_valid = 1'b0; b_in_i = '0; b_in_q = '0; b_out_ready = 1'b0;

    sh_r = '{127, 90, 0, -90, -127, -90, 0, 90};
    sh_q = '{0, 90, 127, 90, 0, -90, -127, -90};
    for (int v = 0; v < 4; v++) vecs[v] = '0;
    vnames[0] = "impulse";       vecs[0].inv = 1'b1; vecs[0].tol = 4'd0;
    vnames[1] = "shift_imp_inv"; vecs[1].inv = 1'b1; vecs[1].tol = 4'd1;
    vnames[2] = "shift_imp_fft"; vecs[2].inv = 1'b0; vecs[2].tol = 4'd1;
    vnames[3] = "dc";            vecs[3].inv = 1'b1; vecs[3].tol = 4'd0;
    vecs[0].xi[0] = 16'd127;
    vecs[1].xi[1] = 16'd127;
    vecs[2].xi[1] = 16'd127;
    for (int m = 0; m < N; m++) begin
      vecs[0].ei[m] = 16'd127;
      vecs[1].ei[m] = 16'(sh_r[m]);
      vecs[1].eq[m] = 16'(sh_q[m]);
      vecs[2].ei[m] = 16'(sh_r[m]);
      vecs[2].eq[m] = 16'(-sh_q[m]);
      vecs[3].xi[m] = 16'(10);
      vecs[3].xq[m] = 16'(-5);
    end
    vecs[3].ei[0] = 16'(80);
    vecs[3].eq[0] = 16'(-40);

    // Reset values, both while held and after release.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1, 0);
    check("rst_out_valid", out_valid, 0, 0);
    check("rst_busy", busy, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_out_last", out_last, 0, 0);
    check("idle_out_index", out_index, 0, 0);
    check("idle_out_i", out_i, 0, 0);
    check("idle_out_q", out_q, 0, 0);
    check("idle_in_ready", in_ready, 1, 0);

    // Table-driven directed frames.
    for (int v = 0; v < 4; v++) begin
      for (int n = 0; n < N; n++) begin
        drv_i[n] = int'($signed(vecs[v].xi[n]));
        drv_q[n] = int'($signed(vecs[v].xq[n]));
        push_exp(int'($signed(vecs[v].ei[n])), int'($signed(vecs[v].eq[n])));
      end
      load_frame(vecs[v].inv, 1'b0, 1'b0);
      wait_compute();
      unload_frame(1'b0, 1'b0);
      score(vnames[v], int'(vecs[v].tol));
    end

    // Backpressure with a second frame pressing in_valid throughout.
    for (int n = 0; n < N; n++) begin
      drv_i[n] = int'($urandom_range(0, 255)) - 128;
      drv_q[n] = int'($urandom_range(0, 255)) - 128;
    end
    model_push(1'b1);
    load_frame(1'b1, 1'b0, 1'b1);
    wait_compute();
    unload_frame(1'b1, 1'b1);
    score("backpressure", 4);

    // Randomized frames against the DFT model.
    for (int f = 0; f < 6; f++) begin
      bit r_inv, r_bp;
      r_inv = 1'($urandom_range(0, 1));
      r_bp  = 1'($urandom_range(0, 1));
      for (int n = 0; n < N; n++) begin
        drv_i[n] = int'($urandom_range(0, 255)) - 128;
        drv_q[n] = int'($urandom_range(0, 255)) - 128;
      end
      model_push(r_inv);
      load_frame(r_inv, 1'b1, 1'b0);
      wait_compute();
      unload_frame(r_bp, 1'b0);
      score($sformatf("rand%0d", f), 4);
    end

    // Reset in the middle of COMPUTE aborts the frame.
    for (int n = 0; n < N; n++) begin
      drv_i[n] = int'($urandom_range(0, 255)) - 128;
      drv_q[n] = int'($urandom_range(0, 255)) - 128;
    end
    load_frame(1'b0, 1'b0, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("mid_busy", busy, 1, 0);
    rst = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 1, 0);
    check("abort_busy", busy, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_out_valid", out_valid, 0, 0);
    check("abort_in_ready2", in_ready, 1, 0);
    check("abort_out_index", out_index, 0, 0);
    set_impulse();
    for (int m = 0; m < N; m++) push_exp(127, 0);
    load_frame(1'b1, 1'b0, 1'b0);
    wait_compute();
    unload_frame(1'b0, 1'b0);
    score("post_reset_impulse", 0);

    // Full-scale DC on the 64-point instance.
    b_inv = 1'b1; b_in_i = 8'h80; b_in_q = 8'h80;
    for (int n = 0; n < NB; n++) begin
      b_in_valid = 1'b1;
      cnt = 0;
      while (!b_in_ready && cnt < 50) begin
        @(posedge clk); #1;
        cnt++;
      end
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    cnt = 0;
    while (!b_out_valid && cnt < 1000) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("b_latency", cnt, 192, 0);
    b_out_ready = 1'b1;
    idx = 0; cyc = 0;
    while (idx < NB && cyc < 200) begin
      @(negedge clk);
      if (b_out_valid) begin
        er = (idx == 0) ? -8192 : 0;
        check($sformatf("b_index%0d", idx), b_out_index, idx, 0);
        check($sformatf("b_re%0d", idx), $signed(b_out_i), er, 0);
        check($sformatf("b_im%0d", idx), $signed(b_out_q), er, 0);
        if (idx == NB - 1) check("b_last", b_out_last, 1, 0);
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("b_count", idx, NB, 0);
    check("b_busy_done", b_busy, 0, 0);
    b_out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ifft_radix2_engine.md
# ifft_radix2_engine

Parametrised iterative radix-2 decimation-in-time transform engine, successor to the fixed 8-point IFFT processor. It accepts one frame of N = 2^LOG2N complex samples over a valid/ready stream and computes an in-place IFFT or FFT, selected per frame. It then streams the N results out in natural order with backpressure. It sits between the subcarrier mapper and the cyclic-prefix inserter in the OFDM transmit path.

## Interface
- LOG2N, 3, log2 of transform size; legal range 3..6 (N = 8..64)
- IW, 8, input sample width per component, signed two's complement
- TW, 12, twiddle width, signed Q1.(TW-1)
- DW (localparam), IW+LOG2N+1, internal and output width per component
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- inv  in  1  mode, 1 = IFFT (+j twiddles), 0 = FFT (−j); sampled with first accepted sample of a frame
- in_valid  in  1  input sample valid
- in_ready  out  1  engine accepts a sample this cycle
- in_i, in_q  in  IW  input sample
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts output
- out_i, out_q  out  DW  output sample
- out_index  out  LOG2N  bin index of current output
- out_last  out  1  high with bin N-1
- busy  out  1  high in COMPUTE and UNLOAD

## Operation
- State machine: LOAD → COMPUTE → UNLOAD → LOAD. Reset enters LOAD.
- LOAD: in_ready=1. Each accept (in_valid & in_ready) sign-extends the sample to DW and writes it to buffer address bitrev(load_cnt). load_cnt runs 0..N-1. inv is latched when load_cnt=0. The accept with load_cnt=N-1 moves the FSM to COMPUTE.
- COMPUTE: stage s = 0..LOG2N-1, butterfly b = 0..N/2-1, one butterfly per clock. The buffer is a register array; both operands are read and both results written in the same cycle.
- Operand addresses: span h = 2^s. top = (b / h)·2h + (b mod h), bot = top + h. Twiddle index k = (b mod h)·(N/2)/h.
- Butterfly: t = bot·W; top' = top + t; bot' = top − t. W = cos(2πk/N) ± j·sin(2πk/N), with + when inv=1.
- Twiddle ROM: quarter-independent full table of N/2 entries, generated at elaboration. Value is round(v·2^(TW-1)), with +1.0 saturated to 2^(TW-1)−1.
- k=0 bypasses the multiplier (t = bot exactly), so impulse and DC frames are exact.
- Product rounding: (x·w + 2^(TW-2)) >>> (TW-1), then add/subtract at DW bits. DW leaves growth headroom, so no saturation is applied.
- No 1/N scaling in either mode.
- After the last butterfly of stage LOG2N-1, the FSM moves to UNLOAD.
- UNLOAD: out_valid=1, outputs present buffer[out_cnt] in natural order, out_index=out_cnt. A handshake advances out_cnt. The handshake at out_cnt=N-1 returns the FSM to LOAD.
- in_valid outside LOAD is ignored (in_ready=0). out_ready outside UNLOAD is ignored.

## Timing
- Reset values: in_ready=1, out_valid=0, out_last=0, out_index=0, out_i=out_q=0, busy=0. All counters and the latched inv are 0; buffer contents are don't-care.
- Load: minimum N cycles, one sample per cycle at full rate.
- COMPUTE: exactly LOG2N·N/2 cycles (N=8: 12; N=64: 192).
- out_valid rises the cycle after the final butterfly write.
- Minimum frame period: N + LOG2N·N/2 + N cycles.
- Backpressure: while out_valid & !out_ready, out_i/out_q/out_index/out_last hold stable.
- in_ready drops in the cycle after the Nth accept.
- The first new-frame accept is possible in the cycle after the out_last handshake.
- rst at any point, including mid-COMPUTE or mid-UNLOAD, aborts the frame immediately: outputs take reset values and the FSM is in LOAD. The partial frame is never emitted.

## Test plan
- Impulse, N=8, inv=1: in0=(127,0), others 0 → all eight outputs (127,0); out_last on index 7; out_valid rises 12 cycles after the 8th accept.
- Shifted impulse, N=8: in1=(127,0).
  - inv=1 → bin1=(90,90) ±1 LSB, bin2=(0,127) ±1.
  - inv=0 → bin1=(90,−90) ±1, bin2=(0,−127) ±1.
- DC, N=8, inv=1: all inputs (10,−5) → bin0=(80,−40), bins 1..7 = (0,0) exactly.
- Full-scale DC, LOG2N=6: all inputs (−128,−128) → bin0=(−8192,−8192), others 0; no wrap at DW=15.
- Backpressure: out_ready toggled 1-0-0-1 pattern → each bin emitted exactly once, in order, with stable data while stalled. A second frame with in_valid held high is not accepted until after out_last.
- Reset mid-COMPUTE (cycle 5): rst pulsed → next cycle in_ready=1, out_valid=0, busy=0. A following impulse frame produces the correct all-127 result.
